// File: rtl/instr_byte_fetcher.sv
// Byte-serial Y86 instruction fetch: reads up to 10 bytes over a req/ack port
// and holds the assembled word until accepted. Define FETCH_LEN_DECODE_EN to stop after icode length.
module instr_byte_fetcher #(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_pc_valid,
  input  logic [63:0] i_pc,
  output logic        o_pc_ready,
  output logic        o_mem_req,
  output logic [63:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_rdata,
  output logic [0:79] o_instr,
  output logic [3:0]  o_instr_len,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic        o_imem_error
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_DONE} state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [3:0]  r_k;
  logic [3:0]  r_len;
  logic [0:79] r_instr;
  logic [3:0]  r_instr_len;
  logic        r_pc_ready;
  logic        r_valid;
  logic        r_err;

  logic [64:0] w_addr;
  logic        w_oob;
  logic        w_fin;
  logic        w_req;

`ifdef FETCH_LEN_DECODE_EN
  function automatic logic [3:0] f_len(input logic [3:0] icode);
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: f_len = 4'd2;
      4'h7, 4'h8:             f_len = 4'd9;
      4'h3, 4'h4, 4'h5:       f_len = 4'd10;
      default:                f_len = 4'd1;
    endcase
  endfunction
`endif

  // 65-bit sum so a PC near 2^64 wrapping around still counts as out of range
  assign w_addr = {1'b0, r_pc} + {61'b0, r_k};
  assign w_oob  = w_addr >= 65'(MEM_SIZE);
  assign w_fin  = (r_k == r_len);
  // Combinational from state so an async reset drops the request immediately
  assign w_req  = (r_state == S_RD) && !w_fin && !w_oob;

  assign o_mem_req     = w_req;
  assign o_mem_addr    = w_req ? w_addr[63:0] : 64'd0;
  assign o_pc_ready    = r_pc_ready;
  assign o_instr       = r_instr;
  assign o_instr_len   = r_instr_len;
  assign o_instr_valid = r_valid;
  assign o_imem_error  = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= 64'd0;
      r_k         <= 4'd0;
      r_len       <= 4'd10;
      r_instr     <= '0;
      r_instr_len <= 4'd0;
      r_pc_ready  <= 1'b1;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_pc_valid) begin
            r_pc       <= i_pc;
            r_k        <= 4'd0;
            r_len      <= 4'd10;
            r_instr    <= '0;
            r_err      <= 1'b0;
            r_pc_ready <= 1'b0;
            r_state    <= S_RD;
          end
        end
        S_RD: begin
          if (w_fin || w_oob) begin
            r_instr_len <= r_k;
            r_err       <= !w_fin;
            r_valid     <= 1'b1;
            r_state     <= S_DONE;
          end else if (i_mem_ack) begin
            r_instr[int'(r_k)*8 +: 8] <= i_mem_rdata;
            r_k <= r_k + 4'd1;
`ifdef FETCH_LEN_DECODE_EN
            if (r_k == 4'd0) r_len <= f_len(i_mem_rdata[7:4]);
`endif
          end
        end
        S_DONE: begin
          if (i_instr_ready) begin
            r_valid    <= 1'b0;
            r_pc_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
